// File: rtl/tile_pack_buffer.sv
// tile_pack_buffer: captures a ROWS x COLS tile of DW-bit elements in arrival
// (row-major) order, then drains it as PACK-element words either row-major or
// transposed, each word tagged with a sequential SRAM write address.
module tile_pack_buffer #(
    parameter int DW   = 8,
    parameter int PACK = 2,
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int AW   = 18
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 mode,
    input  logic [AW-1:0]        base_addr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW*PACK-1:0]   out_data,
    output logic [AW-1:0]        out_addr,
    output logic                 busy,
    output logic                 done
);

    localparam int N  = ROWS * COLS;
    localparam int NW = N / PACK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_DONE} state_t;

    state_t               r_state;
    logic                 r_mode;
    logic [AW-1:0]        r_base;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [DW*PACK-1:0]   r_out_data;
    logic [AW-1:0]        r_out_addr;
    logic                 r_busy;
    logic                 r_done;
    logic [CW-1:0]        r_wcnt;   // elements written so far
    logic [CW-1:0]        r_k;      // next word index to load into the output register
    logic [CW-1:0]        r_outer;  // row (mode 0) or column (mode 1) of next word
    logic [CW-1:0]        r_inner;  // column group (mode 0) or row group (mode 1)
    logic [DW-1:0]        r_mem [N];

    logic                 w_in_hs;
    logic [IW-1:0]        w_wr_idx;
    logic [CW-1:0]        w_inner_last;
    logic [DW*PACK-1:0]   w_word;

    assign w_in_hs      = in_valid && r_in_ready;
    assign w_wr_idx     = r_wcnt[IW-1:0];
    assign w_inner_last = r_mode ? CW'(ROWS / PACK - 1) : CW'(COLS / PACK - 1);

    // Gather the PACK elements of the next word; element p lands in slice p.
    for (genvar p = 0; p < PACK; p++) begin : g_pack
        logic [IW-1:0] w_idx;
        assign w_idx = r_mode
            ? IW'((32'(r_inner) * PACK + p) * COLS + 32'(r_outer))
            : IW'(32'(r_outer) * COLS + 32'(r_inner) * PACK + p);
        assign w_word[p*DW +: DW] = r_mem[w_idx];
    end

    // Tile storage: written on each fill handshake, never cleared.
    always_ff @(posedge clock) begin
        if (w_in_hs) begin
            r_mem[w_wr_idx] <= in_data;
        end
    end

    // Fill/drain controller with registered handshake and status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_mode      <= 1'b0;
            r_base      <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_wcnt      <= '0;
            r_k         <= '0;
            r_outer     <= '0;
            r_inner     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode     <= mode;
                        r_base     <= base_addr;
                        r_wcnt     <= '0;
                        r_k        <= '0;
                        r_outer    <= '0;
                        r_inner    <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (w_in_hs) begin
                        r_wcnt <= r_wcnt + CW'(1);
                        if (r_wcnt == CW'(N - 1)) begin
                            r_in_ready <= 1'b0;
                            r_state    <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // r_k == NW means the word on the output is the last one.
                    if (r_out_valid && out_ready && (r_k == CW'(NW))) begin
                        r_out_valid <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (!r_out_valid || out_ready) begin
                        r_out_data  <= w_word;
                        r_out_addr  <= r_base + AW'(r_k);
                        r_out_valid <= 1'b1;
                        r_k         <= r_k + CW'(1);
                        if (r_inner == w_inner_last) begin
                            r_inner <= '0;
                            r_outer <= r_outer + CW'(1);
                        end else begin
                            r_inner <= r_inner + CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_addr  = r_out_addr;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_tile_pack_buffer.sv
// tb_tile_pack_buffer: directed bench for tile_pack_buffer at the default
// 8x8, DW=8, PACK=2, AW=18 configuration.
module tb_tile_pack_buffer;

    logic        clock;
    logic        reset;
    logic        start;
    logic        mode;
    logic [17:0] base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [17:0] out_addr;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    logic [15:0] got_d [32];
    logic [17:0] got_a [32];

    typedef struct {
        bit          m;
        logic [17:0] base;
        int          k;
        logic [15:0] d;
        logic [17:0] a;
    } vec_t;

    vec_t tbl [8];

    tile_pack_buffer #(.DW(8), .PACK(2), .ROWS(8), .COLS(8), .AW(18)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Element value equals its arrival index, so each word follows from its position.
    function automatic logic [15:0] exp_word(input bit m, input int k);
        int lo;
        int hi;
        if (!m) begin
            lo = 2 * k;
            hi = lo + 1;
        end else begin
            lo = ((k % 4) * 2) * 8 + k / 4;
            hi = lo + 8;
        end
        return {8'(hi), 8'(lo)};
    endfunction

    // One full tile: start, fill 0..63, drain with optional stall/reset/start spam.
    task automatic run_tile(input bit m, input logic [17:0] base, input int stall_k,
                            input int stall_n, input bit rnd, input int rst_k, input bit spam);
        int   n_in = 0, n_out = 0, last_fill = -100, first_ov = -1, last_out = -100;
        int   done_cyc = -1, done_cnt = 0, stall_cnt = 0, ir_after = 0, errs = 0;
        bit   rst_pend = 0;
        logic busy_after = 1'b1;
        for (int i = 0; i < 32; i++) begin
            got_d[i] = 16'hDEAD;
            got_a[i] = 18'h2BEEF;
        end
        mode = m; base_addr = base; start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clock);
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (rst_pend) begin
                reset = 1'b1; start = 1'b0; in_valid = 1'b0;
                @(negedge clock);
                reset = 1'b0;
                chk("rst_mid_out_valid", 32'(out_valid), 0);
                chk("rst_mid_busy", 32'(busy), 0);
                chk("rst_mid_done", 32'(done), 0);
                chk("rst_mid_out_addr", 32'(out_addr), 0);
                chk("rst_mid_out_data", 32'(out_data), 0);
                chk("rst_mid_in_ready", 32'(in_ready), 0);
                for (int i = 0; i < 4; i++) begin
                    @(negedge clock);
                    if (done) done_cnt++;
                end
                chk("rst_mid_no_done", 32'(done_cnt), 0);
                return;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                busy_after = busy;
                break;
            end
            if (out_valid && first_ov < 0) first_ov = cyc;
            if (n_in >= 64 && in_ready) ir_after++;
            start     = spam && (cyc % 7 == 3);
            mode      = ~m;
            base_addr = ~base;
            in_valid  = (n_in >= 64) ? 1'b1 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            in_data   = 8'(n_in);
            out_ready = 1'b1;
            if (stall_k >= 0 && out_valid && n_out == stall_k && stall_cnt < stall_n) begin
                out_ready = 1'b0;
                stall_cnt++;
                chk("stall_data", 32'(out_data), 32'(exp_word(m, stall_k)));
                chk("stall_addr", 32'(out_addr), 32'(18'(base + 18'(stall_k))));
            end
            if (in_valid && in_ready) begin
                if (n_in == 63) last_fill = cyc;
                n_in++;
            end
            if (out_valid && out_ready) begin
                if (n_out < 32) begin
                    got_d[n_out] = out_data;
                    got_a[n_out] = out_addr;
                end
                if (n_out == 31) last_out = cyc;
                n_out++;
                if (rst_k >= 0 && n_out == rst_k + 1) rst_pend = 1;
            end
            @(negedge clock);
        end
        start = 1'b0; in_valid = 1'b0; mode = m; base_addr = base;
        for (int k = 0; k < 32; k++) begin
            if (got_d[k] !== exp_word(m, k) || got_a[k] !== 18'(base + 18'(k))) errs++;
        end
        chk("word_count", 32'(n_out), 32);
        chk("word_errors", 32'(errs), 0);
        chk("in_count", 32'(n_in), 64);
        chk("first_valid_latency", 32'(first_ov - last_fill), 2);
        chk("done_after_last", 32'(done_cyc - last_out), 1);
        chk("done_pulses", 32'(done_cnt), 1);
        chk("busy_after_done", 32'(busy_after), 0);
        chk("in_ready_after_fill", 32'(ir_after), 0);
        if (stall_k >= 0) chk("stall_cycles", 32'(stall_cnt), 32'(stall_n));
    endtask

    initial begin
        tbl[0] = '{1'b0, 18'h00100, 0,  16'h0100, 18'h00100};
        tbl[1] = '{1'b0, 18'h00100, 31, 16'h3F3E, 18'h0011F};
        tbl[2] = '{1'b1, 18'h00100, 0,  16'h0800, 18'h00100};
        tbl[3] = '{1'b1, 18'h00100, 1,  16'h1810, 18'h00101};
        tbl[4] = '{1'b1, 18'h00100, 4,  16'h0901, 18'h00104};
        tbl[5] = '{1'b1, 18'h00100, 31, 16'h3F37, 18'h0011F};
        tbl[6] = '{1'b0, 18'h3FFF0, 15, 16'h1F1E, 18'h3FFFF};
        tbl[7] = '{1'b0, 18'h3FFF0, 16, 16'h2120, 18'h00000};

        reset = 1'b1; start = 1'b0; mode = 1'b0; base_addr = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_addr", 32'(out_addr), 0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 8; i++) begin
            run_tile(tbl[i].m, tbl[i].base, -1, 0, 1'b0, -1, 1'b0);
            chk("vec_data", 32'(got_d[tbl[i].k]), 32'(tbl[i].d));
            chk("vec_addr", 32'(got_a[tbl[i].k]), 32'(tbl[i].a));
        end

        // Sink stalls for 5 cycles while word 3 is on the output.
        run_tile(1'b0, 18'h00100, 3, 5, 1'b0, -1, 1'b0);
        chk("after_stall_word4", 32'(got_d[4]), 32'h0908);

        // Gappy in_valid during fill.
        run_tile(1'b0, 18'h00100, -1, 0, 1'b1, -1, 1'b0);
        chk("gappy_word31", 32'(got_d[31]), 32'h3F3E);

        // Reset right after the word-10 handshake, then a clean tile.
        run_tile(1'b0, 18'h00100, -1, 0, 1'b0, 10, 1'b0);
        run_tile(1'b0, 18'h00100, -1, 0, 1'b0, -1, 1'b0);
        chk("post_rst_word0", 32'(got_d[0]), 32'h0100);
        chk("post_rst_addr31", 32'(got_a[31]), 32'h0011F);

        // Address wrap with start pulses during fill and drain.
        run_tile(1'b0, 18'h3FFF0, -1, 0, 1'b0, -1, 1'b1);
        chk("wrap_addr16", 32'(got_a[16]), 32'h00000);
        chk("wrap_data16", 32'(got_d[16]), 32'h2120);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tile_pack_buffer.md
Name: tile_pack_buffer

Overview:
- Parametrised successor to the fixed 64-byte, 8-to-16-bit tile buffer.
- Captures a ROWS x COLS tile of DW-bit elements arriving from SRAM read data.
- Drains the tile as PACK-element words, either row-major or transposed (column-major), with generated SRAM write addresses.
- Runs its own fill/drain controller. Uses valid/ready handshakes on both sides so it can sit between SRAM readback and the next processing stage.

Parameters:
- DW, 8, element width in bits.
- PACK, 2, elements per output word; output width is DW*PACK.
- ROWS, 8, tile rows; must be divisible by PACK.
- COLS, 8, tile columns; must be divisible by PACK.
- AW, 18, SRAM address width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a tile; sampled only in IDLE
- mode  in  1  0 = row-major drain, 1 = transposed drain; latched on accepted start
- base_addr  in  AW  first output address; latched on accepted start
- in_valid  in  1  in_data valid
- in_ready  out  1  buffer accepts an element
- in_data  in  DW  tile element, row-major arrival order
- out_valid  out  1  out_data/out_addr valid (doubles as SRAM write enable)
- out_ready  in  1  sink accepts word
- out_data  out  DW*PACK  packed word; lowest-indexed element in the LSBs
- out_addr  out  AW  SRAM address for out_data
- busy  out  1  high in FILL, DRAIN and DONE
- done  out  1  one-cycle pulse at end of tile

Behaviour:
- Storage: N = ROWS*COLS entries of DW bits, indexed r*COLS+c. Contents are not cleared by reset.
- States and transitions:
  - IDLE: start=1 latches mode and base_addr, clears counters, goes to FILL.
  - FILL: in_ready=1. Each in_valid&&in_ready cycle writes in_data to buf[r*COLS+c]. c increments; at COLS-1 it wraps to 0 and r increments. Cycles without a handshake change nothing. The N-th handshake moves to DRAIN on the next edge.
  - DRAIN:
    - Word index k runs 0..N/PACK-1.
    - Mode 0: word k holds row k/(COLS/PACK), columns (k%(COLS/PACK))*PACK .. +PACK-1.
    - Mode 1: word k holds column k/(ROWS/PACK), rows (k%(ROWS/PACK))*PACK .. +PACK-1.
    - out_data, out_addr and out_valid are registered. out_valid rises on the first clock edge after DRAIN entry, so the first word is visible two cycles after the last fill handshake.
    - While out_valid && !out_ready: out_data and out_addr are held stable; nothing is skipped or duplicated.
    - On out_valid && out_ready: the next word is presented in the following cycle with no bubble, when out_ready stays high.
    - out_addr = base_addr + k, modulo 2^AW (wraps silently).
    - The handshake of the final word clears out_valid and moves to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Ignored inputs:
  - start outside IDLE.
  - in_valid outside FILL; in_ready is 0 there.
  - mode and base_addr changes after an accepted start.
- Reset values: state IDLE; in_ready, out_valid, busy, done = 0; out_data, out_addr = 0; counters = 0.
- Reset at any point, including mid-FILL or mid-DRAIN, aborts the tile. No done pulse is produced. The next cycle shows the reset values.
- Throughput: one element per cycle in; one word per cycle out.

Test Plan:
1. DW=8, PACK=2, 8x8; mode 0; base 0x00100; in_data = 0..63 back-to-back; out_ready=1 -> 32 words:
   - word0 = 0x0100 at addr 0x00100, word31 = 0x3F3E at addr 0x0011F.
   - First out_valid 2 cycles after the last fill handshake.
   - done high exactly one cycle after the word31 handshake; busy low the cycle after.
2. Same data, mode 1 -> word0 = 0x0800, word1 = 0x1810, word4 = 0x0901, word31 = 0x3F37.
3. Mode 0, out_ready held low 5 cycles while word3 is presented -> out_data = 0x0706 and out_addr = base+3 stable throughout; next word 0x0908; 32 words total.
4. in_valid toggled pseudo-randomly during FILL -> only handshake cycles advance; output identical to scenario 1; in_ready=0 after the 64th element.
5. Reset asserted in DRAIN after word10 handshake -> next cycle out_valid=0, busy=0, out_addr=0, no done. A fresh start with mode 0 then reproduces scenario 1 exactly.
6. base_addr=0x3FFF0, AW=18 -> word16 at addr 0x00000; start pulsed during FILL and DRAIN ignored (mode/base unchanged, no restart).
